// File: rtl/otter_io_pkg.sv
// Shared definitions for the OTTER IOBUS UART transmitter.
//   - word offsets of the DATA / STATUS / CTRL registers inside the window
//   - STATUS bit positions and a helper that packs the STATUS word
//   - transmit FSM state encoding
package otter_io_pkg;

  localparam logic [31:0] DATA_OFS   = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;
  localparam logic [31:0] CTRL_OFS   = 32'h8;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // Bits not named here read as zero.
  function automatic logic [31:0] pack_status(input logic full,
                                              input logic empty,
                                              input logic busy,
                                              input logic ovf,
                                              input logic [ST_COUNT_W-1:0] count);
    logic [31:0] w;
    w = '0;
    w[ST_FULL]  = full;
    w[ST_EMPTY] = empty;
    w[ST_BUSY]  = busy;
    w[ST_OVF]   = ovf;
    w[ST_COUNT_LSB +: ST_COUNT_W] = count;
    return w;
  endfunction

endpackage

// File: rtl/otter_uart_tx_if.sv
// Handshake between the UART transmit core and its byte FIFO.
//   push/wdata : enqueue one byte (ignored when full unless a pop coincides)
//   pop        : dequeue the head (ignored when empty)
//   rdata      : current head byte, valid while !empty
//   full/empty/count : occupancy
// master = transmit core, slave = FIFO.
interface otter_uart_tx_if #(
  parameter int DEPTH = 8
);
  logic                     push;
  logic                     pop;
  logic [7:0]               wdata;
  logic [7:0]               rdata;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;

  modport master (output push, pop, wdata, input rdata, full, empty, count);
  modport slave  (input push, pop, wdata, output rdata, full, empty, count);
endinterface

// File: rtl/otter_fifo.sv
// Synchronous byte FIFO, DEPTH entries (power of two).
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-high reset, empties the FIFO
//   bus  - push/pop/wdata in, rdata/full/empty/count out (slave side)
// A push into a full FIFO is accepted when a pop happens on the same edge.
module otter_fifo #(
  parameter int DEPTH = 8
) (
  input  logic CLK,
  input  logic RST,
  otter_uart_tx_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign bus.full  = (count == (AW+1)'(DEPTH));
  assign bus.empty = (count == '0);
  assign bus.count = count;
  assign bus.rdata = mem[rd_ptr];

  assign do_pop  = bus.pop & ~bus.empty;
  assign do_push = bus.push & (~bus.full | do_pop);

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by
  // the pointers and count, so stale contents are never observable.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= bus.wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/otter_uart_tx.sv
// OTTER IOBUS-mapped UART transmitter (8N1, LSB first) with a byte FIFO.
// Parameters: CLKS_PER_BIT (baud divisor), DEPTH (FIFO entries), BASE_ADDR.
// Ports:
//   CLK, RST            - clock and asynchronous active-high reset
//   IOBUS_ADDR/OUT/WR   - CPU store address, data and one-cycle strobe
//   RD_DATA             - STATUS / CTRL read-back, zero for other addresses
//   TX                  - registered serial line, idles high
//   INTR                - registered level interrupt: ie & empty & ~busy
module otter_uart_tx
  import otter_io_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          DEPTH        = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        TX,
  output logic        INTR
);

  localparam int            BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  otter_uart_tx_if #(.DEPTH(DEPTH)) fifo_bus ();

  otter_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK (CLK),
    .RST (RST),
    .bus (fifo_bus.slave)
  );

  tx_state_e     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          ovf;
  logic          ie;
  logic          live;
  logic          busy;
  logic          frame_end;
  logic          wr_en;
  logic          hit_data;
  logic          hit_status;
  logic          hit_ctrl;
  logic          unused_wdata;

  assign unused_wdata = ^IOBUS_OUT[31:8];

  assign hit_data   = (IOBUS_ADDR == BASE_ADDR + DATA_OFS);
  assign hit_status = (IOBUS_ADDR == BASE_ADDR + STATUS_OFS);
  assign hit_ctrl   = (IOBUS_ADDR == BASE_ADDR + CTRL_OFS);

  // live is low for the first edge after reset release, so a store that
  // overlaps the release is dropped.
  assign wr_en = IOBUS_WR & live;

  assign busy      = (state != S_IDLE);
  assign frame_end = (state == S_STOP) && (baud == BAUD_MAX);

  assign fifo_bus.push  = wr_en & hit_data;
  assign fifo_bus.wdata = IOBUS_OUT[7:0];
  // Pop from IDLE, or directly at the end of STOP so back-to-back frames
  // have no idle bit between them.
  assign fifo_bus.pop   = ~fifo_bus.empty & ((state == S_IDLE) | frame_end);

  // NOTE: every path assigns RD_DATA after the default, so no latch is inferred.
  always_comb begin
    RD_DATA = '0;
    if (hit_status) begin
      RD_DATA = pack_status(fifo_bus.full, fifo_bus.empty, busy, ovf,
                            ST_COUNT_W'(fifo_bus.count));
    end else if (hit_ctrl) begin
      RD_DATA = {31'b0, ie};
    end
  end

  // Transmit FSM. TX is loaded on the edge that enters each bit, so the line
  // changes one edge after the decision and stays glitch-free.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      TX      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_bus.pop) begin
            state <= S_START;
            baud  <= '0;
            shreg <= fifo_bus.rdata;
            TX    <= 1'b0;
          end
        end
        S_START: begin
          if (baud == BAUD_MAX) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= S_DATA;
            TX      <= shreg[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        S_DATA: begin
          if (baud == BAUD_MAX) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              TX    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              TX      <= shreg[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        S_STOP: begin
          if (baud == BAUD_MAX) begin
            baud <= '0;
            if (fifo_bus.pop) begin
              state <= S_START;
              shreg <= fifo_bus.rdata;
              TX    <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file side: overflow flag, interrupt enable, interrupt output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      live <= 1'b0;
      ovf  <= 1'b0;
      ie   <= 1'b0;
      INTR <= 1'b0;
    end else begin
      live <= 1'b1;
      INTR <= ie & fifo_bus.empty & ~busy;
      if (wr_en & hit_status) begin
        ovf <= 1'b0;
      end else if (fifo_bus.push & fifo_bus.full & ~fifo_bus.pop) begin
        ovf <= 1'b1;
      end
      if (wr_en & hit_ctrl) ie <= IOBUS_OUT[0];
    end
  end

endmodule

// File: tb/tb_otter_uart_tx.sv
// Self-checking bench for otter_uart_tx (CLKS_PER_BIT=4, DEPTH=8) plus a
// short standalone check of otter_fifo through its interface.
module tb_otter_uart_tx;
  import otter_io_pkg::*;

  localparam int          C     = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h1100_0100;
  localparam logic [31:0] A_DATA   = BASE + DATA_OFS;
  localparam logic [31:0] A_STATUS = BASE + STATUS_OFS;
  localparam logic [31:0] A_CTRL   = BASE + CTRL_OFS;
  localparam logic [31:0] A_RSVD   = BASE + 32'd12;
  localparam logic [9:0]  A5_SEQ   = 10'b11_0100_1010; // bit b of frame at index b

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [31:0] rd_data;
  logic        tx;
  logic        intr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  otter_uart_tx #(.CLKS_PER_BIT(C), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IOBUS_ADDR (addr),
    .IOBUS_OUT  (wdata),
    .IOBUS_WR   (wr),
    .RD_DATA    (rd_data),
    .TX         (tx),
    .INTR       (intr)
  );

  otter_uart_tx_if #(.DEPTH(4)) fbus ();
  otter_fifo #(.DEPTH(4)) u_fifo (
    .CLK (CLK),
    .RST (RST),
    .bus (fbus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queue + frame timeline ----------------
  logic [7:0] m_q[$];
  bit         m_active;
  int         m_t;        // cycle index inside the current 10*C frame
  logic [7:0] m_byte;
  bit         m_ovf;
  bit         m_ie;
  bit         m_intr;
  bit         m_live;
  bit         m_pop;
  int         m_pre;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_q.delete();
      m_active = 0; m_t = 0; m_ovf = 0; m_ie = 0; m_intr = 0; m_live = 0;
    end else begin
      m_pre  = m_q.size();
      m_intr = m_ie && (m_pre == 0) && !m_active;
      m_pop  = 0;
      if (!m_active) begin
        if (m_pre > 0) m_pop = 1;
      end else if (m_t == 10*C - 1) begin
        if (m_pre > 0) m_pop = 1;
        else m_active = 0;
      end else begin
        m_t++;
      end
      if (m_pop) begin
        m_byte = m_q.pop_front();
        m_active = 1;
        m_t = 0;
      end
      if (wr && m_live) begin
        if (addr == A_DATA) begin
          if (m_pre < DEPTH || m_pop) m_q.push_back(wdata[7:0]);
          else m_ovf = 1;
        end
        if (addr == A_STATUS) m_ovf = 0;
        if (addr == A_CTRL) m_ie = wdata[0];
      end
      m_live = 1;
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [31:0] s;
    s = '0;
    if (a == A_STATUS) begin
      s[0] = (m_q.size() == DEPTH);
      s[1] = (m_q.size() == 0);
      s[2] = m_active;
      s[3] = m_ovf;
      s[10:4] = 7'(m_q.size());
    end else if (a == A_CTRL) begin
      s[0] = m_ie;
    end
    return s;
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      check("tx", 32'(tx), 32'(exp_tx()));
      check("intr", 32'(intr), 32'(m_intr));
      check("rd_data", rd_data, exp_rd(addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge CLK); #1;
    wr = 1'b0; wdata = '0; addr = A_STATUS;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    @(negedge CLK);
    check(name, rd_data, exp);
  endtask

  task automatic wait_idle(input int budget);
    addr = A_STATUS;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (rd_data[1] && !rd_data[2]) break;
    end
    check("drain", rd_data & 32'h6, 32'h2);
  endtask

  task automatic sync();
    @(posedge CLK); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] fq[$];
  logic [9:0] seq;
  int         c_n;
  int         r;
  bit         f_pop;
  bit         f_push;

  initial begin
    fbus.push = 1'b0; fbus.pop = 1'b0; fbus.wdata = '0;
    addr = A_STATUS;
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_status", rd_data, 32'h2);
    #2 RST = 1'b0;
    sync();

    // Standalone FIFO: random push/pop against a queue.
    for (int i = 0; i < 200; i++) begin
      fbus.push  = ($urandom_range(0, 99) < (i < 100 ? 70 : 30));
      fbus.pop   = ($urandom_range(0, 99) < (i < 100 ? 30 : 70));
      fbus.wdata = 8'($urandom);
      @(negedge CLK);
      check("fifo_count", 32'(fbus.count), 32'(fq.size()));
      check("fifo_empty", 32'(fbus.empty), 32'(fq.size() == 0));
      check("fifo_full", 32'(fbus.full), 32'(fq.size() == 4));
      if (fq.size() > 0) check("fifo_head", 32'(fbus.rdata), 32'(fq[0]));
      f_pop  = fbus.pop && (fq.size() > 0);
      f_push = fbus.push && (fq.size() < 4 || f_pop);
      if (f_pop) void'(fq.pop_front());
      if (f_push) fq.push_back(fbus.wdata);
      sync();
    end
    fbus.push = 1'b0; fbus.pop = 1'b0;

    // 8'hA5 frame, upper data bits garbage, ie=0.
    sync();
    bus_write(A_DATA, 32'hFFFF_FFA5);
    @(posedge CLK);
    for (int b = 0; b < 10; b++) begin
      @(negedge CLK);
      seq[b] = tx;
      check("intr_ie0", 32'(intr), 32'd0);
      repeat (C) @(posedge CLK);
    end
    check("a5_frame", 32'(seq), 32'(A5_SEQ));
    #1;

    // Reserved address: reads zero, writes change nothing.
    read_check("rsvd_read", A_RSVD, 32'h0);
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    read_check("rsvd_status", A_STATUS, 32'h2);
    read_check("rsvd_ctrl", A_CTRL, 32'h0);

    // ie=1, three contiguous frames, INTR timing.
    sync();
    bus_write(A_CTRL, 32'h1);
    read_check("ctrl_ie", A_CTRL, 32'h1);
    sync();
    @(negedge CLK);
    check("intr_idle", 32'(intr), 32'd1);
    sync();
    bus_write(A_DATA, 32'($urandom_range(0, 255)));
    c_n = cyc;
    bus_write(A_DATA, 32'($urandom_range(0, 255)));
    bus_write(A_DATA, 32'($urandom_range(0, 255)));
    for (int i = 0; i < 30*C + 40; i++) begin
      @(negedge CLK);
      if (intr) break;
    end
    check("intr_rise_delay", 32'(cyc - c_n), 32'(30*C + 2));
    sync();
    bus_write(A_CTRL, 32'h0);

    // Nine writes while a frame is in flight: ninth dropped, ovf sticky.
    sync();
    bus_write(A_DATA, 32'h0000_003C);
    sync();
    for (int i = 0; i < 9; i++) bus_write(A_DATA, 32'($urandom));
    read_check("ovf_status", A_STATUS, 32'h0000_008D);
    sync();
    bus_write(A_STATUS, $urandom);
    read_check("ovf_clear", A_STATUS, 32'h0000_0085);
    wait_idle(20*10*C);

    // Push into a full FIFO on the same edge as the frame-boundary pop.
    sync();
    bus_write(A_DATA, 32'h0000_0011);
    c_n = cyc;
    for (int i = 0; i < 8; i++) bus_write(A_DATA, 32'($urandom));
    while (cyc < c_n + 10*C) sync();
    bus_write(A_DATA, 32'h0000_00E7);
    read_check("full_pop_push", A_STATUS, 32'h0000_0085);
    wait_idle(20*10*C);

    // Reset during data bit 3 of a frame of zeros.
    sync();
    bus_write(A_DATA, 32'h0000_0000);
    c_n = cyc;
    bus_write(A_DATA, 32'h0000_003C);
    bus_write(A_DATA, 32'h0000_0077);
    while (cyc < c_n + 1 + 4*C + 2) sync();
    @(negedge CLK);
    check("tx_before_rst", 32'(tx), 32'd0);
    #2 RST = 1'b1;
    #1 check("tx_async_rst", 32'(tx), 32'd1);
    check("intr_rst", 32'(intr), 32'd0);
    repeat (2) @(posedge CLK);
    read_check("rst_mid_status", A_STATUS, 32'h2);
    #2 RST = 1'b0;
    addr = A_DATA; wdata = 32'h55; wr = 1'b1;
    @(posedge CLK); #1;
    wr = 1'b0; addr = A_STATUS;
    read_check("wr_ignored_after_rst", A_STATUS, 32'h2);
    repeat (20) sync();

    // Random traffic checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) bus_write(A_DATA, $urandom);
      else if (r < 8) bus_write(A_STATUS, $urandom);
      else if (r < 11) bus_write(A_CTRL, $urandom);
      else if (r < 13) bus_write(A_RSVD, $urandom);
      else begin
        case ($urandom_range(0, 4))
          0: addr = A_DATA;
          1: addr = A_STATUS;
          2: addr = A_CTRL;
          3: addr = A_RSVD;
          default: addr = $urandom;
        endcase
        sync();
      end
    end
    wait_idle(20*10*C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
